button_event: RTL

- Sits directly downstream of the synchronous debouncer and consumes its clean, synchronous, active-high button level.
- Converts the level into single-cycle event pulses: press, release, short-press, long-press and optional auto-repeat.
- Drives capture triggers and register-step controls in the camera control path.
- Single clock domain; all outputs registered.

---
 rtl/button_event.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/button_event.sv
// button_event: turns a debounced, synchronous, active-high button level into
// single-cycle event pulses (press, release, short-press, long-press and an
// optional auto-repeat) plus a "held" level.
//
// Build option: define BUTTON_AUTO_REPEAT_EN to enable periodic repeat_pulse
// events while a long hold continues. When it is undefined, repeat_pulse is
// tied low and the hold counter freezes once the long threshold is reached.
//
// Handshake: none. btn is sampled on every rising clk edge. Each output is
// registered and reflects the btn value sampled at the previous edge.
//
// The FSM state is kept in the signal 'state' (type state_t) so it can be
// probed hierarchically.

module button_event #(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned CNT_WIDTH     = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    // Elaboration-time sanity check of the configuration.
    localparam longint unsigned CNT_SPAN = 64'd1 << CNT_WIDTH;

    if ((LONG_CYCLES < 2) || (REPEAT_CYCLES < 1) ||
        (CNT_SPAN <= 64'(LONG_CYCLES)) || (CNT_SPAN <= 64'(REPEAT_CYCLES))) begin : g_cfg_error
        $error("button_event: invalid LONG_CYCLES/REPEAT_CYCLES/CNT_WIDTH combination");
    end

    localparam logic [CNT_WIDTH-1:0] LONG_CNT = CNT_WIDTH'(LONG_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [CNT_WIDTH-1:0] REPEAT_CNT = CNT_WIDTH'(REPEAT_CYCLES);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] counter;
    logic [CNT_WIDTH-1:0] counter_next;
    logic                 btn_prev;
    logic                 rise;

    logic press_next;
    logic release_next;
    logic short_next;
    logic long_next;
    logic held_next;

`ifdef BUTTON_AUTO_REPEAT_EN
    logic repeat_next;
    logic repeat_q;
`endif

    // Only the rising edge is needed explicitly: in PRESS and LONG the
    // previous sample is always 1, so btn==0 there is already a falling edge.
    assign rise = btn & ~btn_prev;

    // Next-state, counter and event decode; all outputs are registered below.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        press_next   = 1'b0;
        release_next = 1'b0;
        short_next   = 1'b0;
        long_next    = 1'b0;
        held_next    = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
        repeat_next  = 1'b0;
`endif

        case (state)
            IDLE: begin
                counter_next = '0;
                if (rise) begin
                    press_next   = 1'b1;
                    held_next    = 1'b1;
                    counter_next = CNT_ONE;
                    state_next   = PRESS;
                end
            end

            PRESS: begin
                // held stays high through the cycle carrying release_pulse.
                held_next = 1'b1;
                if (!btn) begin
                    // Release wins over a simultaneous long threshold.
                    release_next = 1'b1;
                    short_next   = 1'b1;
                    counter_next = '0;
                    state_next   = IDLE;
                end else if (counter == LONG_CNT) begin
                    long_next    = 1'b1;
                    counter_next = CNT_ONE;
                    state_next   = LONG;
                end else begin
                    counter_next = counter + CNT_ONE;
                end
            end

            LONG: begin
                held_next = 1'b1;
                if (!btn) begin
                    // Release wins over a simultaneous repeat boundary.
                    release_next = 1'b1;
                    counter_next = '0;
                    state_next   = IDLE;
                end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
                    if (counter == REPEAT_CNT) begin
                        repeat_next  = 1'b1;
                        counter_next = CNT_ONE;
                    end else begin
                        counter_next = counter + CNT_ONE;
                    end
`else
                    counter_next = counter;
`endif
                end
            end

            default: begin
                counter_next = '0;
                state_next   = IDLE;
            end
        endcase
    end

    // State, counter, edge history and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            counter       <= '0;
            // A button held through reset must not look like a fresh press.
            btn_prev      <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            held          <= 1'b0;
        end else begin
            state         <= state_next;
            counter       <= counter_next;
            btn_prev      <= btn;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            short_press   <= short_next;
            long_press    <= long_next;
            held          <= held_next;
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    // Registered auto-repeat event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_next;
        end
    end

    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule
